// File: rtl/ps2_kbd.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd
// Purpose  : PS/2 keyboard receiver with an 8-bit scancode FIFO behind a
//            Wishbone-style slave. Register 0 = DATA (read pops), register 1 =
//            STATUS (flags + count, W1C on bits 2..4).
// Option   : define PS2_KBD_IRQ_EN to add the irq_o output.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_data_i,
  output logic [31:0] bus_data_o,
  input  logic        bus_select_i,
  input  logic        bus_we_i,
  output logic        bus_ack_o,
  input  logic        ps2_clk,
  input  logic        ps2_data
`ifdef PS2_KBD_IRQ_EN
  ,output logic       irq_o
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TW-1:0]            TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2, S_STOP = 2'd3;
  localparam logic [1:0] B_IDLE = 2'd0, B_ACK  = 2'd1, B_WAIT = 2'd2;

  logic       r_c_s1, r_c_s2, r_c_prev, r_d_s1, r_d_s2;
  logic       w_fall;
  logic [1:0] r_rx_state, w_rx_next;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_par;
  logic       w_par_ok;
  logic [TW-1:0] r_tmo;
  logic       w_tmo_hit;
  logic       w_push, w_ferr_set, w_perr_set;

  logic [7:0] r_mem [0:DEPTH-1];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic       w_empty, w_full, w_pop, w_do_push, w_ovf_set;
  logic       r_ovf, r_perr, r_ferr;

  logic [1:0]  r_bstate, w_bnext;
  logic        w_acc;
  logic [2:0]  w_clr;
  logic [31:0] w_status, w_cnt32, r_rdata;

  // Two-flop synchronisers; the extra clock flop gives the previous sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_s1 <= 1'b1; r_c_s2 <= 1'b1; r_c_prev <= 1'b1;
      r_d_s1 <= 1'b1; r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= ps2_clk;  r_c_s2 <= r_c_s1; r_c_prev <= r_c_s2;
      r_d_s1 <= ps2_data; r_d_s2 <= r_d_s1;
    end
  end

  assign w_fall    = r_c_prev & ~r_c_s2;
  assign w_par_ok  = ^{r_shift, r_par};
  assign w_tmo_hit = (r_rx_state != S_IDLE) && !w_fall && (r_tmo == TMO_LAST);

  // Receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_state <= S_IDLE;
    else      r_rx_state <= w_rx_next;
  end

  // Receiver next state: one bit per falling edge, timeout aborts silently.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_fall && !r_d_s2)             w_rx_next = S_DATA;
      S_DATA:  if (w_fall && r_bitcnt == 3'd7)    w_rx_next = S_PAR;
      S_PAR:   if (w_fall)                        w_rx_next = S_STOP;
      S_STOP:  if (w_fall)                        w_rx_next = S_IDLE;
      default:                                    w_rx_next = S_IDLE;
    endcase
    if (w_tmo_hit) w_rx_next = S_IDLE;
  end

  // Receiver outputs: frame verdict on the stop-bit edge.
  always_comb begin
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    w_perr_set = 1'b0;
    if (r_rx_state == S_STOP && w_fall) begin
      if (!r_d_s2)       w_ferr_set = 1'b1;
      else if (!w_par_ok) w_perr_set = 1'b1;
      else               w_push     = 1'b1;
    end
  end

  // Receiver datapath: shift register, bit counter, parity latch, timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= 8'h00; r_bitcnt <= 3'd0; r_par <= 1'b0; r_tmo <= '0;
    end else begin
      if (r_rx_state == S_IDLE || w_fall) r_tmo <= '0;
      else                                r_tmo <= r_tmo + 1'b1;
      if (w_fall) begin
        case (r_rx_state)
          S_IDLE: r_bitcnt <= 3'd0;
          S_DATA: begin
            r_shift  <= {r_d_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PAR:  r_par <= r_d_s2;
          default: ;
        endcase
      end
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_acc     = (r_bstate == B_IDLE) && bus_select_i;
  assign w_pop     = w_acc && !bus_we_i && !bus_addr_i[2] && !w_empty;
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_clr     = (w_acc && bus_we_i && bus_addr_i[2]) ? bus_data_i[4:2] : 3'b000;

  // FIFO storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers, occupancy and sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
      r_ovf <= 1'b0; r_perr <= 1'b0; r_ferr <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_pop) r_count <= r_count - 1'b1;
      r_ovf  <= (r_ovf  & ~w_clr[0]) | w_ovf_set;
      r_perr <= (r_perr & ~w_clr[1]) | w_perr_set;
      r_ferr <= (r_ferr & ~w_clr[2]) | w_ferr_set;
    end
  end

  assign w_cnt32  = 32'(r_count);
  assign w_status = {20'h0, w_cnt32[3:0], 3'b000, r_ferr, r_perr, r_ovf, w_full, w_empty};

  // Bus handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bstate <= B_IDLE;
    else      r_bstate <= w_bnext;
  end

  // Bus next state: one ack per select assertion.
  always_comb begin
    w_bnext = r_bstate;
    case (r_bstate)
      B_IDLE:  if (bus_select_i)  w_bnext = B_ACK;
      B_ACK:                      w_bnext = B_WAIT;
      B_WAIT:  if (!bus_select_i) w_bnext = B_IDLE;
      default:                    w_bnext = B_IDLE;
    endcase
  end

  // Bus outputs: ack decoded from state.
  always_comb begin
    bus_ack_o = (r_bstate == B_ACK);
  end

  // Read data captured at access time, zero in every other cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdata <= 32'h0;
    else if (w_acc && !bus_we_i)
      r_rdata <= bus_addr_i[2] ? w_status
                               : {24'h0, (w_empty ? 8'h00 : r_mem[r_rd_ptr])};
    else r_rdata <= 32'h0;
  end

  assign bus_data_o = r_rdata;

`ifdef PS2_KBD_IRQ_EN
  logic r_irq;
  // Interrupt follows "data waiting or any error" one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= !w_empty || r_ovf || r_perr || r_ferr;
  end
  assign irq_o = r_irq;
`endif

  logic w_unused;
  assign w_unused = &{1'b0, bus_addr_i[31:3], bus_addr_i[1:0], bus_data_i[31:5],
                      bus_data_i[1:0], w_cnt32[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd.sv
`default_nettype none
// Bench for ps2_kbd: directed PS/2 frames and bus accesses, a queue-based
// model of the FIFO/flags, and a per-cycle compare of the bus outputs.
module tb_ps2_kbd;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr_i, bus_data_i, bus_data_o;
  logic        bus_select_i, bus_we_i, bus_ack_o;
  logic        ps2_clk, ps2_data;
`ifdef PS2_KBD_IRQ_EN
  logic        irq_o;
`endif

  ps2_kbd #(.FIFO_DEPTH_LOG2(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
    .bus_select_i(bus_select_i), .bus_we_i(bus_we_i), .bus_ack_o(bus_ack_o),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data)
`ifdef PS2_KBD_IRQ_EN
    ,.irq_o(irq_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
  logic [32:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] st_model();
    int n = mq.size();
    return {20'h0, 4'(n), 3'b000, m_ferr, m_perr, m_ovf, (n == 8), (n == 0)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b; tick(3);
    ps2_clk = 1'b0; tick(5);
    ps2_clk = 1'b1; tick(2);
  endtask

  task automatic send(input logic [7:0] d, input logic badpar, input logic stop);
    logic par;
    par = ~(^d) ^ badpar;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    tick(10);
    if (!stop)              m_ferr = 1'b1;
    else if (badpar)        m_perr = 1'b1;
    else if (mq.size() == 8) m_ovf = 1'b1;
    else                    mq.push_back(d);
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output int acks);
    logic [31:0] e;
    e = 32'h0;
    if (!we) begin
      if (addr[2]) e = st_model();
      else if (mq.size() != 0) e = {24'h0, mq.pop_front()};
    end else if (addr[2]) begin
      m_ovf  = m_ovf  & ~wd[2];
      m_perr = m_perr & ~wd[3];
      m_ferr = m_ferr & ~wd[4];
    end
    exp_q.push_back({!we, e});
    bus_addr_i = addr; bus_we_i = we; bus_data_i = wd; bus_select_i = 1'b1;
    acks = 0; rd = 32'h0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus_ack_o) begin acks++; rd = bus_data_o; end
    end
    @(posedge clk); #1;
    bus_select_i = 1'b0;
    tick(2);
    chk("ack_count", 32'(acks), 32'd1);
  endtask

  task automatic rd_lit(input string nm, input logic [31:0] addr, input logic [31:0] lit);
    logic [31:0] v; int a;
    bus_xfer(addr, 1'b0, 32'h0, 3, v, a);
    chk(nm, v, lit);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] v; int a;
    bus_xfer(addr, 1'b1, wd, 3, v, a);
  endtask

  // Per-cycle compare of bus outputs against the model's expectations.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_ack_o) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if (e[32]) chk("rdata_model", bus_data_o, e[31:0]);
        end
      end else begin
        chk("rdata_idle_zero", bus_data_o, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4;

  initial begin
    logic [31:0] v; int a;
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    bus_addr_i = 32'h0; bus_data_i = 32'h0; bus_select_i = 1'b0; bus_we_i = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_ack", 32'(bus_ack_o), 32'd0);
    chk("rst_data", bus_data_o, 32'h0);
`ifdef PS2_KBD_IRQ_EN
    chk("rst_irq", 32'(irq_o), 32'd0);
`endif
    tick(1);
    rst = 1'b1;
    tick(2);
    rd_lit("status_reset", A_STAT, 32'h1);

    // Good frame
    send(8'h1C, 1'b0, 1'b1);
`ifdef PS2_KBD_IRQ_EN
    chk("irq_rise", 32'(irq_o), 32'd1);
`endif
    rd_lit("status_1c", A_STAT, 32'h100);
    rd_lit("data_1c", A_DATA, 32'h1C);
`ifdef PS2_KBD_IRQ_EN
    chk("irq_fall", 32'(irq_o), 32'd0);
`endif
    rd_lit("status_empty", A_STAT, 32'h1);
    rd_lit("data_empty", A_DATA, 32'h0);

    // Parity error and W1C
    send(8'h1C, 1'b1, 1'b1);
    rd_lit("status_perr", A_STAT, 32'h9);
    wr(A_STAT, 32'h08);
    rd_lit("status_perr_clr", A_STAT, 32'h1);

    // Frame error
    send(8'h3C, 1'b0, 1'b0);
    rd_lit("status_ferr", A_STAT, 32'h11);
    wr(A_STAT, 32'h10);
    wr(A_DATA, 32'hFF);
    rd_lit("status_ferr_clr", A_STAT, 32'h1);

    // Overflow
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b1);
    rd_lit("status_full_ovf", A_STAT, 32'h806);
    for (int i = 1; i <= 8; i++) rd_lit("data_drain", A_DATA, 32'(i));
    rd_lit("status_after_drain", A_STAT, 32'h5);
    wr(A_STAT, 32'h1C);
    rd_lit("status_ovf_clr", A_STAT, 32'h1);

    // Timeout of a partial frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(TMO + 10);
    send(8'h5A, 1'b0, 1'b1);
    rd_lit("status_tmo", A_STAT, 32'h100);
    rd_lit("data_tmo", A_DATA, 32'h5A);

    // Long select: single ack, single pop
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    rd_lit("status_two", A_STAT, 32'h200);
    bus_xfer(A_DATA, 1'b0, 32'h0, 5, v, a);
    chk("hold_data", v, 32'h11);
    rd_lit("status_hold", A_STAT, 32'h100);
    rd_lit("data_second", A_DATA, 32'h22);

    // Reset mid-frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b0;
    mq.delete(); exp_q.delete();
    m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    send(8'h6B, 1'b0, 1'b1);
    rd_lit("status_after_rst", A_STAT, 32'h100);
    rd_lit("data_after_rst", A_DATA, 32'h6B);

    tick(3);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_kbd.md
Name: ps2_kbd

Overview:
- Wishbone slave for bus slave port 7, the PS/2 keyboard controller, sitting directly downstream of the system bus.
- Receives PS/2 device-to-host frames from the keyboard pins and checks them.
- Buffers good scancode bytes in a small FIFO.
- The CPU reads scancodes and status through two 32-bit registers.

Parameters:
FIFO_DEPTH_LOG2, 3, log2 of scancode FIFO depth (default 8 entries)
TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge mid-frame before the frame is aborted

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
bus_addr_i  input  32  word address from bus; only bit 2 decoded
bus_data_i  input  32  write data
bus_data_o  output  32  read data, valid while bus_ack_o=1
bus_select_i  input  1  slave select, held by master until ack
bus_we_i  input  1  1=write, 0=read
bus_ack_o  output  1  one-cycle access acknowledge
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous

Behaviour:
- Reset: rst=0 asynchronously clears all state.
  - bus_ack_o=0, bus_data_o=0.
  - FIFO empty, all error flags 0, receiver in IDLE.
- Input sync: ps2_clk and ps2_data pass through 2-FF synchronisers.
  - A falling edge is detected from the synced clock's previous/current samples.
  - Data is sampled on the synced value at the falling-edge cycle.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE, one bit consumed per falling edge.
  - IDLE: edge with data=0 (start bit) -> DATA, bit count 0. Edge with data=1 is ignored.
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: latch the bit; odd parity over the 8 data bits plus parity bit is required.
  - STOP: stop=1 and parity OK -> push byte. Stop=0 -> discard, set frame_err. Bad parity -> discard, set parity_err. Return to IDLE.
  - Timeout counter resets on every falling edge and counts only outside IDLE. Reaching TIMEOUT_CYCLES -> IDLE, partial byte discarded, no flag set.
- FIFO: 2^FIFO_DEPTH_LOG2 x 8 bits; pointers wrap modulo depth; count is FIFO_DEPTH_LOG2+1 bits.
  - Push while full and no pop in the same cycle: byte dropped, overflow flag set.
  - Push and pop in the same cycle: both occur, count unchanged, no overflow even when full.
  - Pop when empty: no pointer change, returns 0.
- Register map, selected by bus_addr_i[2]:
  - 0 = DATA. Read returns {24'h0, FIFO head} and pops exactly once, on the ack cycle. Write is acked and ignored.
  - 1 = STATUS. Read returns: bit0 empty, bit1 full, bit2 overflow, bit3 parity_err, bit4 frame_err, bits[11:8] count (zero-extended), other bits 0.
  - STATUS write: bits 2..4 are write-1-to-clear. A clear coinciding with a new error event leaves the flag set.
- Bus handshake FSM: B_IDLE -> B_ACK -> B_WAIT.
  - B_IDLE with bus_select_i=1: register bus_data_o and perform the access -> B_ACK.
  - B_ACK: bus_ack_o=1 for exactly one cycle -> B_WAIT.
  - B_WAIT: hold until bus_select_i=0 -> B_IDLE. No second ack or pop while select stays high.
  - Latency: ack appears 1 cycle after select is first seen.
  - bus_data_o returns to 0 outside B_ACK.
- Reset mid-frame or mid-access: everything is abandoned. After reset release the receiver waits for the next start bit.

Optional Feature:
- Macro: PS2_KBD_IRQ_EN.
- Defined: adds output port irq_o (1 bit, reset 0).
  - Registered; high on the cycle after FIFO becomes non-empty or any error flag becomes set.
  - Low once the FIFO is empty and all flags are clear.
- Undefined: port and its logic are absent; all other behaviour is identical.

Test Plan:
- Send frame 0x1C (odd parity bit 0, stop 1), then read STATUS -> 0x0000_0100. Read DATA -> 0x0000_001C. Read STATUS -> 0x0000_0001.
- Send 0x1C with parity bit 1 -> STATUS=0x0000_0009 and FIFO empty. Write STATUS 0x08 -> STATUS=0x0000_0001.
- Send 9 frames 0x01..0x09 with no reads -> STATUS=0x0000_0806 (full, overflow, count 8). 8 DATA reads return 0x01..0x08, then STATUS=0x0000_0005.
- Start bit plus 3 data bits, then idle for TIMEOUT_CYCLES+10, then a full frame 0x5A -> only 0x5A queued, no error flags set.
- Hold bus_select_i high for 5 cycles on a DATA read with 2 entries queued -> bus_ack_o high exactly 1 cycle, one pop, count goes 2->1.
- With PS2_KBD_IRQ_EN defined, receive 0x1C -> irq_o rises; read DATA -> irq_o falls within 2 cycles.
